// File: rtl/ctrl_pipe_hazard_if.sv
// Bundle between the ID-stage decoder/IF logic and the control pipeline/hazard unit.
// The master drives the ID-stage instruction fields; the slave returns pipeline controls.
interface ctrl_pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9
);
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              ex_br_taken;

  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_RegWrite;
  logic              wb_MemtoReg;
  logic [REG_AW-1:0] wb_rd;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, ex_br_taken,
    input  pc_stall, ifid_stall, ifid_flush, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
           mem_ctrl, mem_rd, wb_RegWrite, wb_MemtoReg, wb_rd, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, ex_br_taken,
    output pc_stall, ifid_stall, ifid_flush, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
           mem_ctrl, mem_rd, wb_RegWrite, wb_MemtoReg, wb_rd, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use/RAW stall, branch flush and forwarding.
// Define CTRL_PIPE_FWD_EN to enable EX operand forwarding (otherwise RAW hazards stall).
module ctrl_pipe_hazard #(
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  ctrl_pipe_hazard_if.slave pipe
);

  // Control word layout {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp[1:0],Branch,jals}
  localparam int B_MEMTOREG = CTRL_W - 2;
  localparam int B_REGWRITE = CTRL_W - 3;
  localparam int B_MEMREAD  = CTRL_W - 4;

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] mem_ctrl_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_regwrite_q;
  logic              wb_memtoreg_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic              id_hit_ex;
  logic              hazard;
  logic              bubble;
  logic              br_taken;

  // A producer only matters when it writes a non-zero register that the consumer actually reads.
  function automatic logic reg_match(input logic              used,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rd,
                                     input logic              wr);
    return used && (rs != '0) && (rs == rd) && wr;
  endfunction

  function automatic logic id_reads(input logic [REG_AW-1:0] rd, input logic wr);
    return pipe.id_valid &&
           (reg_match(pipe.id_rs1_used, pipe.id_rs1, rd, wr) ||
            reg_match(pipe.id_rs2_used, pipe.id_rs2, rd, wr));
  endfunction

  assign br_taken  = pipe.ex_br_taken;
  assign id_hit_ex = id_reads(ex_rd_q, ex_ctrl_q[B_REGWRITE]);

`ifdef CTRL_PIPE_FWD_EN
  logic              ex_rs1_used_q, ex_rs1_used_d;
  logic              ex_rs2_used_q, ex_rs2_used_d;
  logic              load_use;

  assign load_use = id_hit_ex && ex_ctrl_q[B_MEMREAD];
  assign hazard   = load_use;

  // EX/MEM is the newer producer, so it takes precedence over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] rs);
    if (reg_match(used, rs, mem_rd_q, mem_ctrl_q[B_REGWRITE])) begin
      return 2'b10;
    end else if (reg_match(used, rs, wb_rd_q, wb_regwrite_q)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign pipe.fwd_a = fwd_sel(ex_rs1_used_q, ex_rs1_q);
  assign pipe.fwd_b = fwd_sel(ex_rs2_used_q, ex_rs2_q);
`else
  logic              id_hit_mem;

  // Without forwarding the consumer waits until the producer reaches WB, where the regfile bypasses.
  assign id_hit_mem = id_reads(mem_rd_q, mem_ctrl_q[B_REGWRITE]);
  assign hazard     = id_hit_ex || id_hit_mem;

  assign pipe.fwd_a = 2'b00;
  assign pipe.fwd_b = 2'b00;
`endif

  // A taken branch kills the ID instruction, so it overrides any stall request.
  assign pipe.pc_stall   = hazard && !br_taken;
  assign pipe.ifid_stall = hazard && !br_taken;
  assign pipe.ifid_flush = br_taken;
  assign bubble          = !pipe.id_valid || hazard || br_taken;

  // ID -> ID/EX
  always_comb begin
    ex_ctrl_d = pipe.id_ctrl;
    ex_rs1_d  = pipe.id_rs1;
    ex_rs2_d  = pipe.id_rs2;
    ex_rd_d   = pipe.id_rd;
`ifdef CTRL_PIPE_FWD_EN
    ex_rs1_used_d = pipe.id_rs1_used;
    ex_rs2_used_d = pipe.id_rs2_used;
`endif
    if (bubble) begin
      ex_ctrl_d = '0;
      ex_rs1_d  = '0;
      ex_rs2_d  = '0;
      ex_rd_d   = '0;
`ifdef CTRL_PIPE_FWD_EN
      ex_rs1_used_d = 1'b0;
      ex_rs2_used_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q     <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      mem_ctrl_q    <= '0;
      mem_rd_q      <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_rd_q       <= '0;
`ifdef CTRL_PIPE_FWD_EN
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
`endif
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      // ID/EX -> EX/MEM
      mem_ctrl_q    <= ex_ctrl_q;
      mem_rd_q      <= ex_rd_q;
      // EX/MEM -> MEM/WB
      wb_regwrite_q <= mem_ctrl_q[B_REGWRITE];
      wb_memtoreg_q <= mem_ctrl_q[B_MEMTOREG];
      wb_rd_q       <= mem_rd_q;
`ifdef CTRL_PIPE_FWD_EN
      ex_rs1_used_q <= ex_rs1_used_d;
      ex_rs2_used_q <= ex_rs2_used_d;
`endif
    end
  end

  assign pipe.ex_ctrl     = ex_ctrl_q;
  assign pipe.ex_rs1      = ex_rs1_q;
  assign pipe.ex_rs2      = ex_rs2_q;
  assign pipe.ex_rd       = ex_rd_q;
  assign pipe.mem_ctrl    = mem_ctrl_q;
  assign pipe.mem_rd      = mem_rd_q;
  assign pipe.wb_RegWrite = wb_regwrite_q;
  assign pipe.wb_MemtoReg = wb_memtoreg_q;
  assign pipe.wb_rd       = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: instruction-level pipeline model checked every cycle,
// plus directed hazard sequences with hand-computed stall counts and forward selects.
module tb_ctrl_pipe_hazard;
  localparam int AW = 5;
  localparam int CW = 9;

  localparam logic [CW-1:0] C_LW   = 9'h1E0;
  localparam logic [CW-1:0] C_ADD  = 9'h048;
  localparam logic [CW-1:0] C_ADDI = 9'h140;
  localparam logic [CW-1:0] C_SW   = 9'h110;
  localparam logic [CW-1:0] C_JAL  = 9'h041;

`ifdef CTRL_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          u1;
    logic          u2;
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  ins_t id;
  logic id_v;
  logic br;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Instructions currently in EX, MEM, WB (index 0, 1, 2).
  ins_t stg [3];

  ctrl_pipe_hazard_if #(.REG_AW(AW), .CTRL_W(CW)) bus ();

  ctrl_pipe_hazard #(.REG_AW(AW), .CTRL_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .pipe  (bus)
  );

  assign bus.id_valid    = id_v;
  assign bus.id_ctrl     = id.ctrl;
  assign bus.id_rs1      = id.rs1;
  assign bus.id_rs2      = id.rs2;
  assign bus.id_rd       = id.rd;
  assign bus.id_rs1_used = id.u1;
  assign bus.id_rs2_used = id.u2;
  assign bus.ex_br_taken = br;

  always #5 clk = ~clk;

  function automatic ins_t mk(logic [CW-1:0] c, int rs1, int rs2, int rd, bit u1, bit u2);
    ins_t i;
    i.ctrl = c;
    i.rs1  = AW'(rs1);
    i.rs2  = AW'(rs2);
    i.rd   = AW'(rd);
    i.u1   = u1;
    i.u2   = u2;
    return i;
  endfunction

  function automatic bit writes(ins_t p, logic [AW-1:0] r);
    return p.ctrl[6] && (r != 0) && (p.rd == r);
  endfunction

  function automatic bit id_needs(ins_t p);
    return id_v && ((id.u1 && writes(p, id.rs1)) || (id.u2 && writes(p, id.rs2)));
  endfunction

  function automatic bit m_hazard();
    if (FWD) return id_needs(stg[0]) && stg[0].ctrl[5];
    return id_needs(stg[0]) || id_needs(stg[1]);
  endfunction

  function automatic int m_fwd(bit used, logic [AW-1:0] r);
    if (!FWD || !used) return 0;
    if (writes(stg[1], r)) return 2;
    if (writes(stg[2], r)) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      stg[0] <= '0;
      stg[1] <= '0;
      stg[2] <= '0;
    end else begin
      stg[2] <= stg[1];
      stg[1] <= stg[0];
      stg[0] <= (!id_v || m_hazard() || br) ? '0 : id;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_stall",    32'(bus.pc_stall),    32'(m_hazard() && !br));
      chk("ifid_stall",  32'(bus.ifid_stall),  32'(m_hazard() && !br));
      chk("ifid_flush",  32'(bus.ifid_flush),  32'(br));
      chk("ex_ctrl",     32'(bus.ex_ctrl),     32'(stg[0].ctrl));
      chk("ex_rs1",      32'(bus.ex_rs1),      32'(stg[0].rs1));
      chk("ex_rs2",      32'(bus.ex_rs2),      32'(stg[0].rs2));
      chk("ex_rd",       32'(bus.ex_rd),       32'(stg[0].rd));
      chk("mem_ctrl",    32'(bus.mem_ctrl),    32'(stg[1].ctrl));
      chk("mem_rd",      32'(bus.mem_rd),      32'(stg[1].rd));
      chk("wb_RegWrite", 32'(bus.wb_RegWrite), 32'(stg[2].ctrl[6]));
      chk("wb_MemtoReg", 32'(bus.wb_MemtoReg), 32'(stg[2].ctrl[7]));
      chk("wb_rd",       32'(bus.wb_rd),       32'(stg[2].rd));
      chk("fwd_a",       32'(bus.fwd_a),       32'(m_fwd(stg[0].u1, stg[0].rs1)));
      chk("fwd_b",       32'(bus.fwd_b),       32'(m_fwd(stg[0].u2, stg[0].rs2)));
    end
  end

  task automatic drive(ins_t i, logic v, logic b);
    id   = i;
    id_v = v;
    br   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive('0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  // Hold the instruction in ID until the model lets it into EX; count stall cycles both ways.
  task automatic issue(string name, ins_t i, int exp_stalls);
    int ms   = 0;
    int ds   = 0;
    bit done = 1'b0;
    drive(i, 1'b1, 1'b0);
    for (int k = 0; k < 6 && !done; k++) begin
      #2;
      if (bus.pc_stall) ds++;
      if (m_hazard()) ms++;
      else done = 1'b1;
      tick();
    end
    if (!done) chk({name, " stall bound"}, 32'(0), 32'(1));
    chk({name, " model stalls"}, 32'(ms), 32'(exp_stalls));
    chk({name, " dut stalls"},   32'(ds), 32'(exp_stalls));
    drive('0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive('0, 1'b0, 1'b0);
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fill every stage, then reset mid-stream.
    drive(mk(C_ADD, 1, 2, 3, 1, 1), 1'b1, 1'b0); tick();
    drive(mk(C_LW, 1, 0, 4, 1, 0), 1'b1, 1'b0);  tick();
    drive(mk(C_ADD, 2, 6, 5, 1, 1), 1'b1, 1'b0); tick();
    drive('0, 1'b0, 1'b0);
    #2;
    chk("fill mem_ctrl", 32'(bus.mem_ctrl), 32'(C_LW));
    chk("fill wb_rd", 32'(bus.wb_rd), 32'(3));
    reset = 1'b1;
    drive(mk(C_ADD, 5, 4, 7, 1, 1), 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    drive('0, 1'b0, 1'b0);
    #2;
    chk("rst ex_ctrl", 32'(bus.ex_ctrl), 32'(0));
    chk("rst ex_rd", 32'(bus.ex_rd), 32'(0));
    chk("rst mem_ctrl", 32'(bus.mem_ctrl), 32'(0));
    chk("rst wb_RegWrite", 32'(bus.wb_RegWrite), 32'(0));
    chk("rst wb_rd", 32'(bus.wb_rd), 32'(0));
    chk("rst pc_stall", 32'(bus.pc_stall), 32'(0));
    chk("rst flush", 32'(bus.ifid_flush), 32'(0));
    chk("rst fwd_a", 32'(bus.fwd_a), 32'(0));
    tick();

    // lw x5 ; add x6,x5,x1
    issue("lw x5", mk(C_LW, 1, 0, 5, 1, 0), 0);
    issue("lu add x6", mk(C_ADD, 5, 1, 6, 1, 1), FWD ? 1 : 2);
    #2;
    chk("lu fwd_a", 32'(bus.fwd_a), 32'(FWD ? 1 : 0));
    chk("lu fwd_b", 32'(bus.fwd_b), 32'(0));
    drain();

    // add x5,x1,x2 ; add x7,x5,x5
    issue("add x5", mk(C_ADD, 1, 2, 5, 1, 1), 0);
    issue("raw add x7", mk(C_ADD, 5, 5, 7, 1, 1), FWD ? 0 : 2);
    #2;
    chk("raw fwd_a", 32'(bus.fwd_a), 32'(FWD ? 2 : 0));
    chk("raw fwd_b", 32'(bus.fwd_b), 32'(FWD ? 2 : 0));
    drain();

    // Load-use and taken branch together: branch wins.
    issue("br lw x5", mk(C_LW, 1, 0, 5, 1, 0), 0);
    drive(mk(C_ADD, 5, 1, 6, 1, 1), 1'b1, 1'b1);
    #2;
    chk("br flush", 32'(bus.ifid_flush), 32'(1));
    chk("br pc_stall", 32'(bus.pc_stall), 32'(0));
    chk("br ifid_stall", 32'(bus.ifid_stall), 32'(0));
    tick();
    drive('0, 1'b0, 1'b0);
    #2;
    chk("br ex_ctrl", 32'(bus.ex_ctrl), 32'(0));
    drain();

    // x0 never matches.
    issue("addi x0", mk(C_ADDI, 0, 0, 0, 1, 0), 0);
    issue("add x3,x0,x0", mk(C_ADD, 0, 0, 3, 1, 1), 0);
    #2;
    chk("x0 fwd_a", 32'(bus.fwd_a), 32'(0));
    chk("x0 fwd_b", 32'(bus.fwd_b), 32'(0));
    drain();

    // Store data dependency two instructions back.
    issue("add x5 (sw)", mk(C_ADD, 1, 2, 5, 1, 1), 0);
    drive('0, 1'b0, 1'b0);
    tick();
    issue("sw x5", mk(C_SW, 1, 5, 0, 1, 1), FWD ? 0 : 1);
    #2;
    chk("sw fwd_a", 32'(bus.fwd_a), 32'(0));
    chk("sw fwd_b", 32'(bus.fwd_b), 32'(FWD ? 1 : 0));
    drain();

    // Unused rs field equal to producer rd is not a hazard.
    issue("add x5 (jal)", mk(C_ADD, 1, 2, 5, 1, 1), 0);
    issue("jal rs-unused", mk(C_JAL, 5, 5, 1, 0, 0), 0);
    #2;
    chk("jal fwd_a", 32'(bus.fwd_a), 32'(0));
    drain();

    // Two producers of x5: the newer one is forwarded.
    issue("add x5 old", mk(C_ADD, 1, 2, 5, 1, 1), 0);
    issue("add x5 new", mk(C_ADD, 3, 4, 5, 1, 1), 0);
    issue("add x8,x5,x0", mk(C_ADD, 5, 0, 8, 1, 1), FWD ? 0 : 2);
    #2;
    chk("newest fwd_a", 32'(bus.fwd_a), 32'(FWD ? 2 : 0));
    chk("newest fwd_b", 32'(bus.fwd_b), 32'(0));
    drain();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
